// File: rtl/spi_display_tx.sv
// Byte-wide SPI mode-0 transmitter (MSB first) for the character LCD.
// Accepts a byte on dataRdy, serializes it, and pulses transEna when done.
module spi_display_tx #(
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dataRdy,
  input  logic [7:0] data,
  output logic       transEna,
  output logic       busy,
  output logic       overrun,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             div_done, active, active_nxt;

  assign div_done   = (div_cnt == DIV_LAST);
  assign active     = (state == SETUP) || (state == SHIFT) || (state == HOLD);
  assign active_nxt = (state_nxt == SETUP) || (state_nxt == SHIFT) || (state_nxt == HOLD);
  // shreg is zeroed on the way into DONE, so mosi idles low without extra muxing
  assign mosi       = shreg[7];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dataRdy) state_nxt = SETUP;
      SETUP:   if (div_done) state_nxt = SHIFT;
      SHIFT:   if (div_done && !sclk && bit_cnt == 3'd7) state_nxt = HOLD;
      HOLD:    if (div_done) state_nxt = DONE;
      DONE:    state_nxt = dataRdy ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      transEna <= 1'b0;
      overrun  <= 1'b0;
      sclk     <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      // Control outputs are registered off the next state so they never glitch
      cs_n     <= !active_nxt;
      busy     <= active_nxt;
      transEna <= (state_nxt == DONE);
      if (active && dataRdy) overrun <= 1'b1;
      div_cnt  <= (active && !div_done) ? div_cnt + 1'b1 : '0;
      case (state)
        IDLE, DONE: if (dataRdy) begin
          shreg   <= data;
          bit_cnt <= '0;
        end
        SETUP: if (div_done) sclk <= 1'b1;
        SHIFT: if (div_done) begin
          // bit_cnt indexes the bit on mosi; the last falling edge leaves bit 0 in place
          if (sclk) begin
            sclk <= 1'b0;
            if (bit_cnt != 3'd7) shreg <= {shreg[6:0], 1'b0};
          end else if (bit_cnt != 3'd7) begin
            sclk    <= 1'b1;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        HOLD: if (div_done) shreg <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_display_tx.sv
// Directed bench for spi_display_tx: one DUT at CLK_DIV=4, one at CLK_DIV=1.
module tb_spi_display_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dr4 = 1'b0, dr1 = 1'b0;
  logic [7:0] d4 = '0, d1 = '0;
  logic te4, busy4, ovr4, csn4, sclk4, mosi4;
  logic te1, busy1, ovr1, csn1, sclk1, mosi1;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  spi_display_tx #(.CLK_DIV(4), .DIV_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .dataRdy(dr4), .data(d4), .transEna(te4), .busy(busy4),
    .overrun(ovr4), .cs_n(csn4), .sclk(sclk4), .mosi(mosi4));
  spi_display_tx #(.CLK_DIV(1), .DIV_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .dataRdy(dr1), .data(d1), .transEna(te1), .busy(busy1),
    .overrun(ovr1), .cs_n(csn1), .sclk(sclk1), .mosi(mosi1));

  task automatic drive(input bit sel, input logic r, input logic [7:0] b);
    if (sel) begin dr1 = r; d1 = b; end
    else     begin dr4 = r; d4 = b; end
  endtask

  // Sends one byte (accepting edge = cycle 0) and observes ncyc cycles at negedges.
  task automatic run_byte(input bit sel, input logic [7:0] b, input int ncyc,
                          input int inj_cyc, input logic [7:0] inj,
                          output int te_cyc, output int te_cnt, output int rises,
                          output int low, output logic [7:0] rx);
    logic prev, s_csn, s_sclk, s_mosi, s_te;
    te_cyc = 0; te_cnt = 0; rises = 0; low = 0; rx = '0; prev = 1'b0;
    drive(sel, 1'b1, b);
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      if (c == inj_cyc) drive(sel, 1'b1, inj);
      else              drive(sel, 1'b0, ~b);
      s_csn  = sel ? csn1  : csn4;
      s_sclk = sel ? sclk1 : sclk4;
      s_mosi = sel ? mosi1 : mosi4;
      s_te   = sel ? te1   : te4;
      if (s_csn === 1'b0) low++;
      if (s_sclk === 1'b1 && prev === 1'b0) begin rx = {rx[6:0], s_mosi}; rises++; end
      if (s_te === 1'b1) begin te_cnt++; if (te_cyc == 0) te_cyc = c; end
      prev = s_sclk;
      @(negedge clk);
    end
    drive(sel, 1'b0, 8'h00);
  endtask

  task automatic test_reset;
    int bad;
    rst_n = 1'b0;
    #12;
    checks++; if (csn4 !== 1'b1) begin failures++; $display("FAIL rst_cs_n got=%b exp=1", csn4); end
    checks++; if (sclk4 !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", sclk4); end
    checks++; if (mosi4 !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b exp=0", mosi4); end
    checks++; if (te4 !== 1'b0 || busy4 !== 1'b0 || ovr4 !== 1'b0) begin
      failures++; $display("FAIL rst_flags got te=%b busy=%b ovr=%b exp=000", te4, busy4, ovr4); end
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (csn4 !== 1'b1 || sclk4 !== 1'b0 || mosi4 !== 1'b0 || te4 !== 1'b0 || busy4 !== 1'b0) bad++;
      if (csn1 !== 1'b1 || sclk1 !== 1'b0 || mosi1 !== 1'b0 || te1 !== 1'b0 || busy1 !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL idle_outputs got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_single_a5;
    int tc, tn, rs, lo; logic [7:0] rx;
    run_byte(1'b0, 8'hA5, 80, 0, 8'h00, tc, tn, rs, lo, rx);
    checks++; if (tc != 73) begin failures++; $display("FAIL a5_te_cycle got=%0d exp=73", tc); end
    checks++; if (tn != 1) begin failures++; $display("FAIL a5_te_count got=%0d exp=1", tn); end
    checks++; if (rs != 8) begin failures++; $display("FAIL a5_sclk_rises got=%0d exp=8", rs); end
    checks++; if (lo != 72) begin failures++; $display("FAIL a5_cs_low got=%0d exp=72", lo); end
    checks++; if (rx !== 8'hA5) begin failures++; $display("FAIL a5_mosi got=%h exp=a5", rx); end
    checks++; if (busy4 !== 1'b0 || ovr4 !== 1'b0) begin
      failures++; $display("FAIL a5_idle_after got busy=%b ovr=%b exp=00", busy4, ovr4); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3] = '{8'h38, 8'h0C, 8'h01};
    int te_at [3];
    int n, idx, rs;
    logic [23:0] rx;
    logic prev;
    n = 0; idx = 1; rs = 0; rx = '0; prev = 1'b0;
    te_at = '{0, 0, 0};
    dr4 = 1'b1; d4 = bytes[0];
    for (int cyc = 1; cyc <= 230; cyc++) begin
      @(negedge clk);
      dr4 = 1'b0; d4 = 8'hEE;
      if (sclk4 === 1'b1 && prev === 1'b0) begin rx = {rx[22:0], mosi4}; rs++; end
      prev = sclk4;
      if (te4 === 1'b1) begin
        if (n < 3) te_at[n] = cyc;
        n++;
        if (idx < 3) begin dr4 = 1'b1; d4 = bytes[idx]; idx++; end
      end
    end
    checks++; if (n != 3) begin failures++; $display("FAIL b2b_te_count got=%0d exp=3", n); end
    checks++; if (te_at[0] != 73 || te_at[1] != 146 || te_at[2] != 219) begin
      failures++; $display("FAIL b2b_te_times got=%0d,%0d,%0d exp=73,146,219", te_at[0], te_at[1], te_at[2]); end
    checks++; if (rs != 24 || rx !== 24'h380C01) begin
      failures++; $display("FAIL b2b_bytes got=%h rises=%0d exp=380c01 rises=24", rx, rs); end
    checks++; if (ovr4 !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", ovr4); end
  endtask

  task automatic test_overrun;
    int tc, tn, rs, lo, bad; logic [7:0] rx;
    run_byte(1'b0, 8'hFF, 90, 30, 8'h55, tc, tn, rs, lo, rx);
    checks++; if (rx !== 8'hFF || rs != 8) begin
      failures++; $display("FAIL ovr_byte got=%h rises=%0d exp=ff rises=8", rx, rs); end
    checks++; if (tn != 1 || tc != 73) begin
      failures++; $display("FAIL ovr_te got count=%0d cycle=%0d exp=1,73", tn, tc); end
    checks++; if (ovr4 !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", ovr4); end
    bad = 0;
    repeat (10) begin @(negedge clk); if (ovr4 !== 1'b1 || csn4 !== 1'b1) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL ovr_sticky got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_reset_mid;
    int tc, tn, rs, lo, bad; logic [7:0] rx;
    dr4 = 1'b1; d4 = 8'h96;
    @(posedge clk);
    for (int c = 1; c < 40; c++) begin @(negedge clk); dr4 = 1'b0; end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (csn4 !== 1'b1 || sclk4 !== 1'b0 || mosi4 !== 1'b0) begin
      failures++; $display("FAIL midrst_pins got cs_n=%b sclk=%b mosi=%b exp=100", csn4, sclk4, mosi4); end
    checks++; if (te4 !== 1'b0 || busy4 !== 1'b0 || ovr4 !== 1'b0) begin
      failures++; $display("FAIL midrst_flags got te=%b busy=%b ovr=%b exp=000", te4, busy4, ovr4); end
    bad = 0;
    repeat (3) begin @(negedge clk); if (te4 !== 1'b0) bad++; end
    rst_n = 1'b1;
    repeat (40) begin @(negedge clk); if (te4 !== 1'b0 || csn4 !== 1'b1) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL midrst_no_te got=%0d bad cycles exp=0", bad); end
    run_byte(1'b0, 8'h3C, 80, 0, 8'h00, tc, tn, rs, lo, rx);
    checks++; if (rx !== 8'h3C || tc != 73 || tn != 1) begin
      failures++; $display("FAIL midrst_next got=%h te_cyc=%0d te_cnt=%0d exp=3c,73,1", rx, tc, tn); end
  endtask

  task automatic test_div1;
    int tc, tn, rs, lo; logic [7:0] rx;
    run_byte(1'b1, 8'h81, 30, 0, 8'h00, tc, tn, rs, lo, rx);
    checks++; if (tc != 19 || tn != 1) begin
      failures++; $display("FAIL div1_te got cycle=%0d count=%0d exp=19,1", tc, tn); end
    checks++; if (rx !== 8'h81 || rs != 8) begin
      failures++; $display("FAIL div1_mosi got=%h rises=%0d exp=81 rises=8", rx, rs); end
    checks++; if (lo != 18) begin failures++; $display("FAIL div1_cs_low got=%0d exp=18", lo); end
  endtask

  initial begin
    test_reset;
    test_single_a5;
    test_back_to_back;
    test_overrun;
    test_reset_mid;
    test_div1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
